// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master bus arbiter and the bridges that
// reuse its watchdog.
//   - ARB_IDLE / ARB_GNT0 / ARB_GNT1 : FSM state encodings
//   - ARB_ERR_WORD                   : default read data returned on timeout
//   - arb_pick_m1()                  : tie-break / winner selection helper
package bus_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_GNT0 = 2'd1;
    localparam logic [1:0] ARB_GNT1 = 2'd2;

    localparam logic [31:0] ARB_ERR_WORD = 32'hDEAD_BEEF;

    // Returns 1 when master 1 should receive the bus. A lone requester always
    // wins; on a tie, fixed priority favours master 0, and round-robin favours
    // whichever master was not served last (last_m1 = 1 means master 1 was).
    function automatic logic arb_pick_m1(input logic req0,
                                         input logic req1,
                                         input logic last_m1,
                                         input logic fixed_prio);
        if (req0 && req1) begin
            return !(fixed_prio || last_m1);
        end
        return req1 && !req0;
    endfunction

endpackage

// File: rtl/bus_arbiter_watchdog.sv
// arb_watchdog: transaction watchdog counter for bus bridges.
//   clk    : clock
//   rst_n  : asynchronous active-low reset, counter to 0
//   clr    : synchronous clear (held while no transaction is in flight)
//   en     : count enable (one increment per cycle of an open transaction)
//   expire : high while the count equals TIMEOUT-1
// The count saturates at TIMEOUT-1, so it never wraps even if the owner
// keeps it enabled one cycle longer than expected.
module arb_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    assign expire = (count == LAST_COUNT);

    // Clear has priority so a fresh grant always starts from count 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expire) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master arbiter in front of a single slave bus.
//   Parameters : FIXED_PRIO (0 round-robin, 1 master 0 wins ties),
//                TIMEOUT (watchdog limit, >= 2), ERR_WORD (timeout read data)
//   Masters    : m0_/m1_ a, d, we, rd in; spo, ready out
//   Slave      : s_a, s_d, s_we, s_rd out; s_spo, s_ready in
//   Status     : grant (one-hot owner, 00 idle), err (timeout pulse)
// Only the FSM state, the last-served pointer and the watchdog count are
// registered; every output is decoded from them and the live inputs.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int          FIXED_PRIO = 0,
    parameter int          TIMEOUT    = 1024,
    parameter logic [31:0] ERR_WORD   = ARB_ERR_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] m0_a,
    input  logic [31:0] m0_d,
    input  logic        m0_we,
    input  logic        m0_rd,
    output logic [31:0] m0_spo,
    output logic        m0_ready,
    input  logic [31:0] m1_a,
    input  logic [31:0] m1_d,
    input  logic        m1_we,
    input  logic        m1_rd,
    output logic [31:0] m1_spo,
    output logic        m1_ready,
    output logic [31:0] s_a,
    output logic [31:0] s_d,
    output logic        s_we,
    output logic        s_rd,
    input  logic [31:0] s_spo,
    input  logic        s_ready,
    output logic [1:0]  grant,
    output logic        err
);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        last_m1;
    logic        last_m1_nxt;
    logic        req0;
    logic        req1;
    logic        own0;
    logic        own1;
    logic        owner_req;
    logic        expire;
    logic        done;
    logic [31:0] resp_word;

    assign req0 = m0_we | m0_rd;
    assign req1 = m1_we | m1_rd;
    assign own0 = (state == ARB_GNT0);
    assign own1 = (state == ARB_GNT1);

    // A grant whose owner has dropped its request is an abort; it never
    // completes, even if the slave happens to raise s_ready that cycle.
    assign owner_req = (own0 & req0) | (own1 & req1);
    assign done      = owner_req & (s_ready | expire);

    arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == ARB_IDLE),
        .en    (own0 | own1),
        .expire(expire)
    );

    // Next-state and last-served pointer. Every grant passes back through
    // IDLE, which keeps a held strobe from being issued twice.
    always_comb begin
        state_nxt   = state;
        last_m1_nxt = last_m1;
        case (state)
            ARB_IDLE: begin
                if (req0 || req1) begin
                    state_nxt = arb_pick_m1(req0, req1, last_m1, FIXED_PRIO != 0)
                              ? ARB_GNT1 : ARB_GNT0;
                end
            end
            ARB_GNT0, ARB_GNT1: begin
                if (!owner_req) begin
                    state_nxt = ARB_IDLE;
                end else if (done) begin
                    state_nxt   = ARB_IDLE;
                    last_m1_nxt = own1;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // State registers; last_m1 resets to 1 so master 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ARB_IDLE;
            last_m1 <= 1'b1;
        end else begin
            state   <= state_nxt;
            last_m1 <= last_m1_nxt;
        end
    end

    // Request path: owner's signals forwarded unchanged, zeros when idle.
    always_comb begin
        s_a  = '0;
        s_d  = '0;
        s_we = 1'b0;
        s_rd = 1'b0;
        if (own0) begin
            s_a  = m0_a;
            s_d  = m0_d;
            s_we = m0_we;
            s_rd = m0_rd;
        end else if (own1) begin
            s_a  = m1_a;
            s_d  = m1_d;
            s_we = m1_we;
            s_rd = m1_rd;
        end
    end

    // A real slave response beats a simultaneous timeout.
    assign resp_word = s_ready ? s_spo : ERR_WORD;

    assign grant    = {own1, own0};
    assign m0_ready = own0 & done;
    assign m1_ready = own1 & done;
    assign m0_spo   = m0_ready ? resp_word : '0;
    assign m1_spo   = m1_ready ? resp_word : '0;
    assign err      = owner_req & expire & ~s_ready;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: a directed vector table, hand-written
// corner-case sequences and a randomized run against a transaction-level
// reference model. Two instances share stimulus: round-robin and fixed
// priority, both with TIMEOUT = 8.
module tb_bus_arbiter;

    localparam int TO = 8;
    localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst_n;
    logic [31:0] m0_a, m0_d, m1_a, m1_d, s_spo;
    logic        m0_we, m0_rd, m1_we, m1_rd, s_ready;

    logic [31:0] m0_spo_r, m1_spo_r, s_a_r, s_d_r;
    logic        m0_ready_r, m1_ready_r, s_we_r, s_rd_r, err_r;
    logic [1:0]  grant_r;
    logic [31:0] m0_spo_f, m1_spo_f, s_a_f, s_d_f;
    logic        m0_ready_f, m1_ready_f, s_we_f, s_rd_f, err_f;
    logic [1:0]  grant_f;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(.FIXED_PRIO(0), .TIMEOUT(TO)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .m0_a(m0_a), .m0_d(m0_d), .m0_we(m0_we), .m0_rd(m0_rd),
        .m0_spo(m0_spo_r), .m0_ready(m0_ready_r),
        .m1_a(m1_a), .m1_d(m1_d), .m1_we(m1_we), .m1_rd(m1_rd),
        .m1_spo(m1_spo_r), .m1_ready(m1_ready_r),
        .s_a(s_a_r), .s_d(s_d_r), .s_we(s_we_r), .s_rd(s_rd_r),
        .s_spo(s_spo), .s_ready(s_ready), .grant(grant_r), .err(err_r)
    );

    bus_arbiter #(.FIXED_PRIO(1), .TIMEOUT(TO)) dut_fix (
        .clk(clk), .rst_n(rst_n),
        .m0_a(m0_a), .m0_d(m0_d), .m0_we(m0_we), .m0_rd(m0_rd),
        .m0_spo(m0_spo_f), .m0_ready(m0_ready_f),
        .m1_a(m1_a), .m1_d(m1_d), .m1_we(m1_we), .m1_rd(m1_rd),
        .m1_spo(m1_spo_f), .m1_ready(m1_ready_f),
        .s_a(s_a_f), .s_d(s_d_f), .s_we(s_we_f), .s_rd(s_rd_f),
        .s_spo(s_spo), .s_ready(s_ready), .grant(grant_f), .err(err_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        m0_rd, m0_we, m1_rd, m1_we, s_ready;
        logic [31:0] s_spo;
        logic [1:0]  grant;
        logic        m0_ready, m1_ready, err;
        logic [31:0] spo0, spo1;
    } vec_t;

    vec_t vecs[11];

    // Reference model: who owns the bus, how long it has owned it, and who
    // was served last (0 or 1). Index 0 = round-robin, 1 = fixed priority.
    int mOwner[2];
    int mAge[2];
    int mLast[2];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic clearInputs();
        m0_we = 0; m0_rd = 0; m1_we = 0; m1_rd = 0;
        m0_a = 32'h1000; m1_a = 32'h2000;
        m0_d = 32'hAAAA_0000; m1_d = 32'hBBBB_0000;
        s_ready = 0; s_spo = '0;
    endtask

    // Leaves the bench just after a rising edge with reset released.
    task automatic resetDut();
        rst_n = 1'b0;
        clearInputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            mOwner[k] = -1;
            mAge[k]   = 0;
            mLast[k]  = 1;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        m0_rd = v.m0_rd; m0_we = v.m0_we;
        m1_rd = v.m1_rd; m1_we = v.m1_we;
        s_ready = v.s_ready; s_spo = v.s_spo;
    endtask

    task automatic modelExpect(input int k, output logic [1:0] g,
                               output logic r0, output logic r1, output logic e,
                               output logic [31:0] spo0, output logic [31:0] spo1,
                               output logic [31:0] sa, output logic [31:0] sd,
                               output logic swe, output logic srd);
        logic busy;
        logic fin;
        g = 2'b00; r0 = 0; r1 = 0; e = 0; spo0 = '0; spo1 = '0;
        sa = '0; sd = '0; swe = 0; srd = 0; busy = 0;
        if (mOwner[k] == 0) begin
            g = 2'b01; sa = m0_a; sd = m0_d; swe = m0_we; srd = m0_rd;
            busy = m0_we | m0_rd;
        end else if (mOwner[k] == 1) begin
            g = 2'b10; sa = m1_a; sd = m1_d; swe = m1_we; srd = m1_rd;
            busy = m1_we | m1_rd;
        end
        fin = busy && (s_ready || mAge[k] == TO - 1);
        e   = busy && !s_ready && mAge[k] == TO - 1;
        if (fin && mOwner[k] == 0) begin
            r0 = 1; spo0 = s_ready ? s_spo : DEAD;
        end
        if (fin && mOwner[k] == 1) begin
            r1 = 1; spo1 = s_ready ? s_spo : DEAD;
        end
    endtask

    task automatic modelStep(input int k);
        bit q0, q1, busy;
        q0 = m0_we | m0_rd;
        q1 = m1_we | m1_rd;
        if (mOwner[k] < 0) begin
            if (q0 && q1)
                mOwner[k] = (k == 1 || mLast[k] == 1) ? 0 : 1;
            else if (q0)
                mOwner[k] = 0;
            else if (q1)
                mOwner[k] = 1;
            mAge[k] = 0;
        end else begin
            busy = (mOwner[k] == 0) ? q0 : q1;
            if (!busy) begin
                mOwner[k] = -1;
            end else if (s_ready || mAge[k] == TO - 1) begin
                mLast[k]  = mOwner[k];
                mOwner[k] = -1;
            end else begin
                mAge[k]++;
            end
        end
    endtask

    task automatic checkModel(input int k);
        logic [1:0]  g;
        logic        r0, r1, e, swe, srd;
        logic [31:0] spo0, spo1, sa, sd;
        modelExpect(k, g, r0, r1, e, spo0, spo1, sa, sd, swe, srd);
        if (k == 0) begin
            checkOutput("rnd_rr_grant", {30'd0, grant_r}, {30'd0, g});
            checkOutput("rnd_rr_ready", {30'd0, m1_ready_r, m0_ready_r}, {30'd0, r1, r0});
            checkOutput("rnd_rr_err", {31'd0, err_r}, {31'd0, e});
            checkOutput("rnd_rr_spo0", m0_spo_r, spo0);
            checkOutput("rnd_rr_spo1", m1_spo_r, spo1);
            checkOutput("rnd_rr_sa", s_a_r, sa);
            checkOutput("rnd_rr_sd", s_d_r, sd);
            checkOutput("rnd_rr_strb", {30'd0, s_we_r, s_rd_r}, {30'd0, swe, srd});
        end else begin
            checkOutput("rnd_fx_grant", {30'd0, grant_f}, {30'd0, g});
            checkOutput("rnd_fx_ready", {30'd0, m1_ready_f, m0_ready_f}, {30'd0, r1, r0});
            checkOutput("rnd_fx_err", {31'd0, err_f}, {31'd0, e});
            checkOutput("rnd_fx_spo0", m0_spo_f, spo0);
            checkOutput("rnd_fx_spo1", m1_spo_f, spo1);
            checkOutput("rnd_fx_sa", s_a_f, sa);
            checkOutput("rnd_fx_strb", {30'd0, s_we_f, s_rd_f}, {30'd0, swe, srd});
        end
    endtask

    initial begin
        int t;
        bit lastRdy0, lastRdy1;
        logic [1:0]  g;
        logic        r0, r1, e, swe, srd;
        logic [31:0] spo0, spo1, sa, sd;

        rst_n = 1'b1;
        clearInputs();

        // {m0_rd, m0_we, m1_rd, m1_we, s_ready, s_spo, grant, m0_rdy, m1_rdy, err, spo0, spo1}
        vecs[0]  = '{0, 0, 0, 0, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,        32'h0};
        vecs[1]  = '{1, 0, 0, 0, 1, 32'h12345678, 2'b00, 0, 0, 0, 32'h0,        32'h0};
        vecs[2]  = '{1, 0, 0, 0, 1, 32'h12345678, 2'b01, 1, 0, 0, 32'h12345678, 32'h0};
        vecs[3]  = '{0, 0, 0, 0, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,        32'h0};
        vecs[4]  = '{1, 0, 1, 0, 1, 32'h11,       2'b00, 0, 0, 0, 32'h0,        32'h0};
        vecs[5]  = '{1, 0, 1, 0, 1, 32'h11,       2'b10, 0, 1, 0, 32'h0,        32'h11};
        vecs[6]  = '{1, 0, 1, 0, 1, 32'h22,       2'b00, 0, 0, 0, 32'h0,        32'h0};
        vecs[7]  = '{1, 0, 1, 0, 1, 32'h22,       2'b01, 1, 0, 0, 32'h22,       32'h0};
        vecs[8]  = '{1, 0, 1, 0, 1, 32'h33,       2'b00, 0, 0, 0, 32'h0,        32'h0};
        vecs[9]  = '{1, 0, 1, 0, 1, 32'h33,       2'b10, 0, 1, 0, 32'h0,        32'h33};
        vecs[10] = '{0, 0, 0, 0, 1, 32'h44,       2'b00, 0, 0, 0, 32'h0,        32'h0};

        // Directed table on the round-robin instance, starting from reset.
        resetDut();
        @(negedge clk);
        checkOutput("reset_grant", {30'd0, grant_r}, 32'd0);
        checkOutput("reset_s_a", s_a_r, 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_grant", i), {30'd0, grant_r}, {30'd0, vecs[i].grant});
            checkOutput($sformatf("vec%0d_m0_ready", i), {31'd0, m0_ready_r}, {31'd0, vecs[i].m0_ready});
            checkOutput($sformatf("vec%0d_m1_ready", i), {31'd0, m1_ready_r}, {31'd0, vecs[i].m1_ready});
            checkOutput($sformatf("vec%0d_err", i), {31'd0, err_r}, {31'd0, vecs[i].err});
            checkOutput($sformatf("vec%0d_spo0", i), m0_spo_r, vecs[i].spo0);
            checkOutput($sformatf("vec%0d_spo1", i), m1_spo_r, vecs[i].spo1);
            if (vecs[i].grant == 2'b01) begin
                checkOutput($sformatf("vec%0d_s_a", i), s_a_r, 32'h1000);
                checkOutput($sformatf("vec%0d_s_rd", i), {31'd0, s_rd_r}, 32'd1);
            end
            @(posedge clk); #1;
        end

        // Contention from reset: both masters hold reads, slave always ready.
        resetDut();
        m0_rd = 1; m1_rd = 1; s_ready = 1; s_spo = 32'h55;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i % 2 == 1) begin
                checkOutput("cont_rr_grant", {30'd0, grant_r}, ((i / 2) % 2 == 0) ? 32'd1 : 32'd2);
                checkOutput("cont_rr_m0_ready", {31'd0, m0_ready_r}, ((i / 2) % 2 == 0) ? 32'd1 : 32'd0);
                checkOutput("cont_rr_m1_ready", {31'd0, m1_ready_r}, ((i / 2) % 2 == 0) ? 32'd0 : 32'd1);
                checkOutput("cont_fx_grant", {30'd0, grant_f}, 32'd1);
            end else begin
                checkOutput("cont_rr_idle", {30'd0, grant_r}, 32'd0);
            end
            checkOutput("cont_fx_m1_ready", {31'd0, m1_ready_f}, 32'd0);
            @(posedge clk); #1;
        end

        // Timeout: m1 writes, slave never answers.
        resetDut();
        m1_we = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 1) checkOutput("to_grant", {30'd0, grant_r}, 32'd2);
            if (i == 1) checkOutput("to_s_we", {31'd0, s_we_r}, 32'd1);
            if (i == 7) checkOutput("to_err_early", {31'd0, err_r}, 32'd0);
            if (i == 7) checkOutput("to_ready_early", {31'd0, m1_ready_r}, 32'd0);
            if (i == 8) begin
                checkOutput("to_err", {31'd0, err_r}, 32'd1);
                checkOutput("to_ready", {31'd0, m1_ready_r}, 32'd1);
                checkOutput("to_spo", m1_spo_r, DEAD);
                checkOutput("to_m0_ready", {31'd0, m0_ready_r}, 32'd0);
            end
            if (i == 9) checkOutput("to_idle", {30'd0, grant_r}, 32'd0);
            @(posedge clk); #1;
        end

        // Abort: m0 drops its read before the slave answers.
        resetDut();
        m0_rd = 1;
        @(posedge clk); #1;
        checkOutput("abort_grant", {30'd0, grant_r}, 32'd1);
        @(posedge clk); #1;
        m0_rd = 0;
        #1;
        checkOutput("abort_ready", {31'd0, m0_ready_r}, 32'd0);
        checkOutput("abort_err", {31'd0, err_r}, 32'd0);
        @(posedge clk); #1;
        checkOutput("abort_idle", {30'd0, grant_r}, 32'd0);
        m0_rd = 1; m1_rd = 1;
        @(posedge clk); #1;
        checkOutput("abort_tie", {30'd0, grant_r}, 32'd1);

        // Reset during a master 1 write takes effect without a clock edge.
        resetDut();
        m1_we = 1;
        @(posedge clk); #1;
        checkOutput("rstmid_grant", {30'd0, grant_r}, 32'd2);
        checkOutput("rstmid_s_we", {31'd0, s_we_r}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstmid_grant_low", {30'd0, grant_r}, 32'd0);
        checkOutput("rstmid_s_we_low", {31'd0, s_we_r}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m1_we = 0; m0_rd = 1; m1_rd = 1;
        @(posedge clk); #1;
        checkOutput("rstmid_tie", {30'd0, grant_r}, 32'd1);
        checkOutput("rstmid_s_a", s_a_r, 32'h1000);

        // Randomized run against the reference model, both instances.
        resetDut();
        lastRdy0 = 0; lastRdy1 = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (m0_we | m0_rd) begin
                if (lastRdy0 || $urandom_range(15) == 0) begin m0_we = 0; m0_rd = 0; end
            end else if ($urandom_range(1) == 0) begin
                t = $urandom_range(15);
                m0_rd = (t < 8 || t == 15); m0_we = (t >= 8);
                m0_a = $urandom; m0_d = $urandom;
            end
            if (m1_we | m1_rd) begin
                if (lastRdy1 || $urandom_range(15) == 0) begin m1_we = 0; m1_rd = 0; end
            end else if ($urandom_range(1) == 0) begin
                t = $urandom_range(15);
                m1_rd = (t < 8 || t == 15); m1_we = (t >= 8);
                m1_a = $urandom; m1_d = $urandom;
            end
            s_ready = ($urandom_range(4) == 0);
            s_spo = $urandom;
            @(negedge clk);
            checkModel(0);
            checkModel(1);
            modelExpect(0, g, r0, r1, e, spo0, spo1, sa, sd, swe, srd);
            lastRdy0 = r0; lastRdy1 = r1;
            @(posedge clk);
            modelStep(0);
            modelStep(1);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
